// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states and iteration count.
package mdu_pkg;

    localparam int unsigned MDU_ITER = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StCalc,
        StFix,
        StWb
    } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl_if.sv
// Execute-stage request / HI-LO writeback bundle of the multiply/divide unit.
// Build option MDU_DIV0_EXC_EN adds the div0_err signal.
interface mdu_ctrl_if #(
    parameter int unsigned WIDTH = mdu_pkg::MDU_ITER
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_wdata;
    logic [WIDTH-1:0] lo_wdata;
    logic             hi_w;
    logic             lo_w;
`ifdef MDU_DIV0_EXC_EN
    logic             div0_err;

    modport master (
        output start, op, rs_data, rt_data, cancel,
        input  busy, done, hi_wdata, lo_wdata, hi_w, lo_w, div0_err
    );
    modport slave (
        input  start, op, rs_data, rt_data, cancel,
        output busy, done, hi_wdata, lo_wdata, hi_w, lo_w, div0_err
    );
`else
    modport master (
        output start, op, rs_data, rt_data, cancel,
        input  busy, done, hi_wdata, lo_wdata, hi_w, lo_w
    );
    modport slave (
        input  start, op, rs_data, rt_data, cancel,
        output busy, done, hi_wdata, lo_wdata, hi_w, lo_w
    );
`endif
endinterface

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration on the {acc, q} pair: shift-add multiply or restoring-divide step.
module mdu_iter_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_i} + (q_i[0] ? {1'b0, m_i} : '0);
        shifted = {acc_i, q_i[WIDTH-1]};
        // Partial remainder stays below 2*m, so the top bit of diff is a clean borrow flag.
        diff    = shifted - {1'b0, m_i};
        if (div_i) begin
            if (!diff[WIDTH]) begin
                acc_o = diff[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = shifted[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[WIDTH:1];
            q_o   = {sum[0], q_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer driving the HI/LO register write ports.
// Build option MDU_DIV0_EXC_EN: divide by zero raises div0_err instead of writing HI/LO.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_ITER
) (
    input logic       mdu_ctrl_clk,
    input logic       mdu_ctrl_rst_n,
    mdu_ctrl_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
`ifdef MDU_DIV0_EXC_EN
    localparam bit Div0Exc = 1'b1;
`else
    localparam bit Div0Exc = 1'b0;
`endif

    mdu_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] rs_q, rs_d, rt_q, rt_d;
    logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d;
    logic             neg_q, neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d;
    logic [WIDTH-1:0] hi_wdata_q, hi_wdata_d, lo_wdata_q, lo_wdata_d;
    logic             hi_w_q, hi_w_d, lo_w_q, lo_w_d, done_q, done_d;
`ifdef MDU_DIV0_EXC_EN
    logic             div0_err_q, div0_err_d;
`endif

    logic               accept;
    logic               div0_trap;
    logic               sgn;
    logic [WIDTH-1:0]   step_acc, step_q;
    logic [2*WIDTH-1:0] prod;

    assign accept    = bus.start && (state_q == StIdle || state_q == StWb);
    assign div0_trap = Div0Exc && bus.op[1] && (bus.rt_data == '0);
    assign sgn       = !op_q[0];
    assign prod      = neg_q ? ('0 - {acc_q, q_q}) : {acc_q, q_q};

    mdu_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .div_i (op_q[1]),
        .acc_i (acc_q),
        .q_i   (q_q),
        .m_i   (m_q),
        .acc_o (step_acc),
        .q_o   (step_q)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        acc_d      = acc_q;
        q_d        = q_q;
        m_d        = m_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div0_d     = div0_q;
        hi_wdata_d = hi_wdata_q;
        lo_wdata_d = lo_wdata_q;
        hi_w_d     = 1'b0;
        lo_w_d     = 1'b0;
        done_d     = 1'b0;
`ifdef MDU_DIV0_EXC_EN
        div0_err_d = 1'b0;
`endif
        unique case (state_q)
            StIdle, StWb: begin
                state_d = StIdle;
                if (accept) begin
                    if (!bus.op[2]) begin
                        if (!div0_trap) begin
                            state_d = StPrep;
                            op_d    = bus.op[1:0];
                            rs_d    = bus.rs_data;
                            rt_d    = bus.rt_data;
                        end
`ifdef MDU_DIV0_EXC_EN
                        else begin
                            div0_err_d = 1'b1;
                        end
`endif
                    end else if (bus.op == OP_MTHI) begin
                        state_d    = StWb;
                        hi_w_d     = 1'b1;
                        done_d     = 1'b1;
                        hi_wdata_d = bus.rs_data;
                    end else if (bus.op == OP_MTLO) begin
                        state_d    = StWb;
                        lo_w_d     = 1'b1;
                        done_d     = 1'b1;
                        lo_wdata_d = bus.rs_data;
                    end
                end
            end
            StPrep: begin
                acc_d     = '0;
                q_d       = (sgn && rs_q[WIDTH-1]) ? ('0 - rs_q) : rs_q;
                m_d       = (sgn && rt_q[WIDTH-1]) ? ('0 - rt_q) : rt_q;
                neg_d     = sgn && (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
                rem_neg_d = sgn && rs_q[WIDTH-1];
                div0_d    = op_q[1] && (rt_q == '0);
                cnt_d     = '0;
                state_d   = StCalc;
            end
            StCalc: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (!op_q[1]) begin
                    hi_wdata_d = prod[2*WIDTH-1:WIDTH];
                    lo_wdata_d = prod[WIDTH-1:0];
                end else if (div0_q) begin
                    lo_wdata_d = '1;
                    hi_wdata_d = rs_q;
                end else begin
                    lo_wdata_d = neg_q ? ('0 - q_q) : q_q;
                    hi_wdata_d = rem_neg_q ? ('0 - acc_q) : acc_q;
                end
                hi_w_d  = 1'b1;
                lo_w_d  = 1'b1;
                done_d  = 1'b1;
                state_d = StWb;
            end
            default: state_d = StIdle;
        endcase
        // A flush wins over everything; strobes already registered for this WB cycle still go out.
        if (bus.cancel) begin
            state_d    = StIdle;
            hi_w_d     = 1'b0;
            lo_w_d     = 1'b0;
            done_d     = 1'b0;
            hi_wdata_d = hi_wdata_q;
            lo_wdata_d = lo_wdata_q;
`ifdef MDU_DIV0_EXC_EN
            div0_err_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge mdu_ctrl_clk or negedge mdu_ctrl_rst_n) begin
        if (!mdu_ctrl_rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            m_q        <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div0_q     <= 1'b0;
            hi_wdata_q <= '0;
            lo_wdata_q <= '0;
            hi_w_q     <= 1'b0;
            lo_w_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MDU_DIV0_EXC_EN
            div0_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            m_q        <= m_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div0_q     <= div0_d;
            hi_wdata_q <= hi_wdata_d;
            lo_wdata_q <= lo_wdata_d;
            hi_w_q     <= hi_w_d;
            lo_w_q     <= lo_w_d;
            done_q     <= done_d;
`ifdef MDU_DIV0_EXC_EN
            div0_err_q <= div0_err_d;
`endif
        end
    end

    // The issue-cycle term stalls the requesting instruction before the FSM has moved.
    assign bus.busy = (state_q == StPrep) || (state_q == StCalc) || (state_q == StFix) ||
                      (bus.start && !bus.op[2] && (state_q == StIdle || state_q == StWb));
    assign bus.done     = done_q;
    assign bus.hi_w     = hi_w_q;
    assign bus.lo_w     = lo_w_q;
    assign bus.hi_wdata = hi_wdata_q;
    assign bus.lo_wdata = lo_wdata_q;
`ifdef MDU_DIV0_EXC_EN
    assign bus.div0_err = div0_err_q;
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed plan vectors plus randomized ops vs. an arithmetic model.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mdu_ctrl_if #(.WIDTH(32)) bus ();

    mdu_ctrl #(
        .WIDTH (32)
    ) dut (
        .mdu_ctrl_clk   (clk),
        .mdu_ctrl_rst_n (rst_n),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic, no knowledge of the iteration scheme.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic hw, output logic lw, output int lat);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        hi = '0; lo = '0; hw = 1'b1; lw = 1'b1; lat = 35;
        sa = $signed(a); sb = $signed(b);
        case (o)
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                hi = sp[63:32]; lo = sp[31:0];
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32]; lo = up[31:0];
            end
            OP_DIV: begin
                if (b == 0) begin lo = '1; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
                else begin lo = sa / sb; hi = sa % sb; end
            end
            OP_DIVU: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            OP_MTHI: begin hi = a; lw = 1'b0; lat = 1; end
            OP_MTLO: begin lo = a; hw = 1'b0; lat = 1; end
            default: begin hw = 1'b0; lw = 1'b0; lat = 0; end
        endcase
    endfunction

    // Issues one op and waits (bounded) for done; lat = -1 if done never came.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output logic hw, output logic lw, output int lat, output int busy_bad);
        busy_bad = 0; lat = -1; hi = '0; lo = '0; hw = 1'b0; lw = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
        #1;
        if (bus.busy !== ~o[2]) busy_bad++;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done === 1'b1) begin
                lat = c; hi = bus.hi_wdata; lo = bus.lo_wdata; hw = bus.hi_w; lw = bus.lo_w;
                if (bus.busy !== 1'b0) busy_bad++;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.hi_w, bus.lo_w} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000", {bus.busy, bus.done, bus.hi_w, bus.lo_w});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.hi_wdata, bus.lo_wdata} !== 64'd0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {bus.hi_wdata, bus.lo_wdata});
        end
        checks++;
        if ({bus.busy, bus.done, bus.hi_w, bus.lo_w} !== 4'b0) begin
            failures++;
            $display("FAIL post_reset_ctrl: got %b expected 0000",
                     {bus.busy, bus.done, bus.hi_w, bus.lo_w});
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic test_directed();
        vec_t        v[6];
        logic [31:0] hi, lo;
        logic        hw, lw;
        int          lat, bb;
        v[0] = '{OP_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        v[1] = '{OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        v[2] = '{OP_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[3] = '{OP_DIVU,  32'd100,        32'd7,         32'd2,         32'd14};
        v[4] = '{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        v[5] = '{OP_DIV,   32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, hi, lo, hw, lw, lat, bb);
            checks++;
            if (lat !== 35 || bb !== 0 || hw !== 1'b1 || lw !== 1'b1) begin
                failures++;
                $display("FAIL dir%0d_timing: got lat=%0d busy_err=%0d hw=%b lw=%b expected 35/0/1/1",
                         i, lat, bb, hw, lw);
            end
            checks++;
            if (hi !== v[i].hi || lo !== v[i].lo) begin
                failures++;
                $display("FAIL dir%0d_result: got %h_%h expected %h_%h", i, hi, lo, v[i].hi, v[i].lo);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b, hi, lo, ehi, elo;
        logic        hw, lw, ehw, elw;
        int          lat, elat, bb;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 5));
            a = $urandom;
            b = $urandom;
            if (i % 5 == 2) b = $urandom_range(1, 15);
            if (i % 11 == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
`ifndef MDU_DIV0_EXC_EN
            if (i % 7 == 3) b = '0;
`else
            if (b == '0) b = 32'd3;
`endif
            model(o, a, b, ehi, elo, ehw, elw, elat);
            run_op(o, a, b, hi, lo, hw, lw, lat, bb);
            checks++;
            if (lat !== elat || bb !== 0 || hw !== ehw || lw !== elw) begin
                failures++;
                $display("FAIL rnd%0d_ctrl op=%0d: got lat=%0d busy_err=%0d hw=%b lw=%b exp %0d/0/%b/%b",
                         i, o, lat, bb, hw, lw, elat, ehw, elw);
            end
            checks++;
            if ((ehw && hi !== ehi) || (elw && lo !== elo)) begin
                failures++;
                $display("FAIL rnd%0d_data op=%0d a=%h b=%h: got %h_%h expected %h_%h",
                         i, o, a, b, hi, lo, ehi, elo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ehi, elo;
        logic        ehw, elw;
        int          elat, lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MTLO; bus.rs_data = 32'h1234_5678; bus.rt_data = '0;
        @(negedge clk);
        checks++;
        if (bus.lo_w !== 1'b1 || bus.hi_w !== 1'b0 || bus.done !== 1'b1 ||
            bus.lo_wdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL b2b_mtlo: got lo_w=%b hi_w=%b done=%b lo=%h expected 1/0/1/12345678",
                     bus.lo_w, bus.hi_w, bus.done, bus.lo_wdata);
        end
        bus.op = OP_MULT; bus.rs_data = 32'd7; bus.rt_data = 32'hFFFF_FFFD;
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_issue_busy: got %b expected 1", bus.busy);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.lo_w !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_after_wb: got lo_w=%b busy=%b expected 0/1", bus.lo_w, bus.busy);
        end
        model(OP_MULT, 32'd7, 32'hFFFF_FFFD, ehi, elo, ehw, elw, elat);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done === 1'b1) begin lat = c; break; end
            @(negedge clk);
        end
        checks++;
        if (lat !== elat || bus.hi_wdata !== ehi || bus.lo_wdata !== elo) begin
            failures++;
            $display("FAIL b2b_mult: got lat=%0d %h_%h expected %0d %h_%h",
                     lat, bus.hi_wdata, bus.lo_wdata, elat, ehi, elo);
        end
    endtask

    task automatic test_cancel();
        int bad = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.rs_data = $urandom; bus.rt_data = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.hi_w, bus.lo_w} !== 4'b0) begin
            failures++;
            $display("FAIL cancel_idle: got %b expected 0000", {bus.busy, bus.done, bus.hi_w, bus.lo_w});
        end
        repeat (40) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.hi_w !== 1'b0 || bus.lo_w !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL cancel_quiet: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b, hi, lo, ehi, elo;
        logic        hw, lw, ehw, elw;
        int          lat, elat, bb;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_data = $urandom; bus.rt_data = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (21) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.hi_w, bus.lo_w} !== 4'b0 ||
            {bus.hi_wdata, bus.lo_wdata} !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid: got ctrl=%b data=%h expected 0000 / 0",
                     {bus.busy, bus.done, bus.hi_w, bus.lo_w}, {bus.hi_wdata, bus.lo_wdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = $urandom; b = $urandom;
        model(OP_MULT, a, b, ehi, elo, ehw, elw, elat);
        run_op(OP_MULT, a, b, hi, lo, hw, lw, lat, bb);
        checks++;
        if (lat !== elat || bb !== 0 || hi !== ehi || lo !== elo) begin
            failures++;
            $display("FAIL reset_mid_mult: got lat=%0d busy_err=%0d %h_%h expected %0d 0 %h_%h",
                     lat, bb, hi, lo, elat, ehi, elo);
        end
    endtask

    task automatic test_nop();
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd6; bus.rs_data = $urandom; bus.rt_data = $urandom;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL nop_busy: got %b expected 0", bus.busy);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.hi_w, bus.lo_w} !== 4'b0) begin
            failures++;
            $display("FAIL nop_ignored: got %b expected 0000", {bus.busy, bus.done, bus.hi_w, bus.lo_w});
        end
    endtask

    task automatic test_div0();
`ifdef MDU_DIV0_EXC_EN
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_data = 32'd5; bus.rt_data = '0;
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL div0_issue_busy: got %b expected 1", bus.busy);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if ({bus.div0_err, bus.busy, bus.done, bus.hi_w, bus.lo_w} !== 5'b10000) begin
            failures++;
            $display("FAIL div0_err: got %b expected 10000",
                     {bus.div0_err, bus.busy, bus.done, bus.hi_w, bus.lo_w});
        end
        @(negedge clk);
        checks++;
        if ({bus.div0_err, bus.busy, bus.done} !== 3'b000) begin
            failures++;
            $display("FAIL div0_pulse: got %b expected 000", {bus.div0_err, bus.busy, bus.done});
        end
`else
        logic [31:0] hi, lo;
        logic        hw, lw;
        int          lat, bb;
        run_op(OP_DIVU, 32'd5, 32'd0, hi, lo, hw, lw, lat, bb);
        checks++;
        if (lat !== 35 || bb !== 0 || hi !== 32'd5 || lo !== 32'hFFFF_FFFF || !hw || !lw) begin
            failures++;
            $display("FAIL div0_divu: got lat=%0d busy_err=%0d %h_%h expected 35 0 00000005_ffffffff",
                     lat, bb, hi, lo);
        end
        run_op(OP_DIV, 32'hFFFF_FFF8, 32'd0, hi, lo, hw, lw, lat, bb);
        checks++;
        if (lat !== 35 || hi !== 32'hFFFF_FFF8 || lo !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div0_div: got lat=%0d %h_%h expected 35 fffffff8_ffffffff", lat, hi, lo);
        end
`endif
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.rs_data = '0; bus.rt_data = '0; bus.cancel = 1'b0;
        test_reset();
        test_directed();
        test_nop();
        test_back_to_back();
        test_div0();
        test_cancel();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
